// File: rtl/popcount_seq_ctrl.sv
// Sequential popcount: one 15-bit slice per cycle through a shared 15:4 compressor.
// Optional POPCNT_THRESH_EN adds a thresh input and an out_ge compare flag.
module adder_15to4 (
  input  logic [14:0] i,
  output logic [3:0]  o
);
  always_comb begin
    o = '0;
    for (int k = 0; k < 15; k++)
      o = o + {3'b000, i[k]};
  end
endmodule

module popcount_seq_ctrl #(
  parameter int VEC_W = 60,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
`ifdef POPCNT_THRESH_EN
  ,
  input  logic [CNT_W-1:0] thresh,
  output logic             out_ge
`endif
);
  localparam int NCHUNK = (VEC_W + 14) / 15;
  localparam int PAD_W  = NCHUNK * 15;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PAD_W-1:0] shift_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] sum;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       slice_cnt;
  logic             accept;
  logic             last;

  adder_15to4 u_cmp (
    .i (shift_q[14:0]),
    .o (slice_cnt)
  );

  assign accept = in_valid & in_ready;
  assign last   = (idx_q == IDX_W'(NCHUNK - 1));
  assign sum    = acc_q + CNT_W'(slice_cnt);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) & ~reset;
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) | (state_q == DONE);
  end

  // Padding bits above VEC_W are zero, so they never add to the sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      shift_q <= PAD_W'(in_vec);
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      shift_q <= shift_q >> 15;
      acc_q   <= sum;
      idx_q   <= idx_q + 1'b1;
      if (last) count_q <= sum;
    end
  end

  assign out_count = count_q;

`ifdef POPCNT_THRESH_EN
  logic [CNT_W-1:0] thresh_q;
  logic             ge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_q <= '0;
      ge_q     <= 1'b0;
    end else if (accept) begin
      thresh_q <= thresh;
    end else if ((state_q == RUN) && last) begin
      ge_q <= (sum >= thresh_q);
    end
  end

  assign out_ge = ge_q;
`endif

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Directed bench for popcount_seq_ctrl: vector table plus handshake/reset corners.
// Also covers 20-bit and 15-bit builds via extra instances.
module tb_popcount_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [59:0] in_vec;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [5:0]  out_count;
`ifdef POPCNT_THRESH_EN
  logic [5:0]  thresh;
  logic        out_ge;
`endif

  popcount_seq_ctrl #(.VEC_W(60), .CNT_W(6)) u60 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
`ifdef POPCNT_THRESH_EN
    ,
    .thresh    (thresh),
    .out_ge    (out_ge)
`endif
  );

  logic        v20, rdy20, ov20, busy20;
  logic [19:0] vec20;
  logic [4:0]  cnt20;
  logic        v15, rdy15, ov15, busy15;
  logic [14:0] vec15;
  logic [3:0]  cnt15;
  logic        ordy_s;
`ifdef POPCNT_THRESH_EN
  logic [4:0]  th20;
  logic        ge20;
  logic [3:0]  th15;
  logic        ge15;
`endif

  popcount_seq_ctrl #(.VEC_W(20), .CNT_W(5)) u20 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v20),
    .in_ready  (rdy20),
    .in_vec    (vec20),
    .out_valid (ov20),
    .out_ready (ordy_s),
    .out_count (cnt20),
    .busy      (busy20)
`ifdef POPCNT_THRESH_EN
    ,
    .thresh    (th20),
    .out_ge    (ge20)
`endif
  );

  popcount_seq_ctrl #(.VEC_W(15), .CNT_W(4)) u15 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v15),
    .in_ready  (rdy15),
    .in_vec    (vec15),
    .out_valid (ov15),
    .out_ready (ordy_s),
    .out_count (cnt15),
    .busy      (busy15)
`ifdef POPCNT_THRESH_EN
    ,
    .thresh    (th15),
    .out_ge    (ge15)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [59:0] vec;
    logic [5:0]  th;
    logic [5:0]  cnt;
    logic        ge;
  } vec_t;

  vec_t tbl[9];

  // Present a vector, wait for accept, then count edges until out_valid.
  task automatic do_vec(input logic [59:0] v, input logic [5:0] th,
                        output int lat, output logic [5:0] cnt,
                        output logic ge);
    int w;
    in_vec   = v;
`ifdef POPCNT_THRESH_EN
    thresh   = th;
`endif
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) check("accept_timeout", w, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    cnt = out_count;
`ifdef POPCNT_THRESH_EN
    ge = out_ge;
`else
    ge = 1'b0;
`endif
    if (th == 6'h3f) ge = 1'b0;
  endtask

  initial begin
    int          lat;
    int          n;
    logic [5:0]  cnt;
    logic        ge;
    logic        pulse;

    tbl[0] = '{"ones",   60'hFFF_FFFF_FFFF_FFFF, 6'd60, 6'd60, 1'b1};
    tbl[1] = '{"zero",   60'h000_0000_0000_0000, 6'd1,  6'd0,  1'b0};
    tbl[2] = '{"alt",    60'hAAA_AAAA_AAAA_AAAA, 6'd30, 6'd30, 1'b1};
    tbl[3] = '{"lsb",    60'h000_0000_0000_0001, 6'd2,  6'd1,  1'b0};
    tbl[4] = '{"msb",    60'h800_0000_0000_0000, 6'd1,  6'd1,  1'b1};
    tbl[5] = '{"chunk0", 60'h000_0000_0000_7FFF, 6'd15, 6'd15, 1'b1};
    tbl[6] = '{"mixed",  60'h123_4567_89AB_CDEF, 6'd33, 6'd32, 1'b0};
    tbl[7] = '{"t31",    60'h000_0000_7FFF_FFFF, 6'd31, 6'd31, 1'b1};
    tbl[8] = '{"t30",    60'h000_0000_3FFF_FFFF, 6'd31, 6'd30, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    v20 = 1'b0; vec20 = '0; v15 = 1'b0; vec15 = '0; ordy_s = 1'b1;
`ifdef POPCNT_THRESH_EN
    thresh = '0; th20 = '0; th15 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef POPCNT_THRESH_EN
    check("rst_out_ge", out_ge, 0);
`endif
    reset = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    // Back-to-back vectors with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_vec(tbl[i].vec, tbl[i].th, lat, cnt, ge);
      check({tbl[i].name, "_lat"}, lat, 4);
      check({tbl[i].name, "_cnt"}, cnt, tbl[i].cnt);
`ifdef POPCNT_THRESH_EN
      check({tbl[i].name, "_ge"}, ge, tbl[i].ge);
`endif
      @(posedge clk); #1;
      check({tbl[i].name, "_handoff_ov"}, out_valid, 0);
      check({tbl[i].name, "_handoff_rdy"}, in_ready, 1);
    end

    // Backpressure in DONE with in_valid held high.
    out_ready = 1'b0;
    do_vec(tbl[0].vec, tbl[0].th, lat, cnt, ge);
    check("bp_cnt", cnt, 60);
    in_vec   = '0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_ov", out_valid, 1);
      check("bp_hold", out_count, 60);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    check("bp_release_ov", out_valid, 0);
    check("bp_release_rdy", in_ready, 1);
    check("bp_release_hold", out_count, 60);
    do_vec(60'h0, 6'd0, lat, cnt, ge);
    check("held_vec_lat", lat, 4);
    check("held_vec_cnt", cnt, 0);
    @(posedge clk); #1;

    do_vec(tbl[6].vec, tbl[6].th, lat, cnt, ge);
    check("pre_rst_cnt", cnt, 32);
    @(posedge clk); #1;

    // Reset landing on the second RUN cycle.
    in_vec   = tbl[0].vec;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_cnt", out_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", in_ready, 1);
    pulse = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulse = 1'b1;
    end
    check("mid_rst_no_pulse", pulse, 0);
    do_vec(tbl[2].vec, tbl[2].th, lat, cnt, ge);
    check("post_rst_lat", lat, 4);
    check("post_rst_cnt", cnt, 30);
    @(posedge clk); #1;

    // Narrow builds: 20 bits padded to two slices, 15 bits in one.
    vec20 = 20'hF_FFFF;
    v20   = 1'b1;
    @(posedge clk); #1;
    v20 = 1'b0;
    n = 0;
    while (!ov20 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w20_lat", n, 2);
    check("w20_cnt", cnt20, 20);

    vec15 = 15'h7FFF;
    v15   = 1'b1;
    @(posedge clk); #1;
    v15 = 1'b0;
    n = 0;
    while (!ov15 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w15_lat", n, 1);
    check("w15_cnt", cnt15, 15);
    @(posedge clk); #1;
    check("w15_idle", rdy15, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
